// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline write-back stage and register file.
package mips_pkg;

  // Default datapath and register-index widths
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;

  // Architectural register file geometry
  localparam int         REG_COUNT = 32;
  localparam logic [4:0] ZERO_REG  = 5'd0;

endpackage

// File: rtl/wb_mux.sv
// Write-back source select: load data or ALU result under MemToReg.
module wb_mux
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_mem_to_reg,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic [DATA_W-1:0] i_alu_data,
  output logic [DATA_W-1:0] o_wb_data
);

  // Pick memory data for loads, ALU result otherwise
  always_comb begin
    o_wb_data = '0;
    if (i_mem_to_reg) begin
      o_wb_data = i_mem_data;
    end else begin
      o_wb_data = i_alu_data;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus 32x32 architectural register file with
// same-cycle write-through bypass on both ID read ports. $0 reads as zero.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  MemToReg,
  input  logic                  RegWrite,
  input  logic [DATA_W-1:0]     MemReadData,
  input  logic [DATA_W-1:0]     address,
  input  logic [REG_ADDR_W-1:0] writeReg,
  input  logic [REG_ADDR_W-1:0] readReg1,
  input  logic [REG_ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0]     readData1,
  output logic [DATA_W-1:0]     readData2,
  output logic [DATA_W-1:0]     wbData,
  output logic                  wbValid
);

  localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] r_regs [REG_COUNT];
  logic [DATA_W-1:0] w_wb_data;
  logic              w_commit;

  wb_mux #(
    .DATA_W (DATA_W)
  ) u_wb_mux (
    .i_mem_to_reg (MemToReg),
    .i_mem_data   (MemReadData),
    .i_alu_data   (address),
    .o_wb_data    (w_wb_data)
  );

  assign wbData  = w_wb_data;
  assign wbValid = w_commit;

  // A commit happens only outside reset and never targets $0
  always_comb begin
    w_commit = 1'b0;
    if (reset) begin
      w_commit = 1'b0;
    end else if (RegWrite && (writeReg != ZERO_IDX)) begin
      w_commit = 1'b1;
    end else begin
      w_commit = 1'b0;
    end
  end

  // Register array: reset clears everything and overrides a same-edge write
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[writeReg] <= w_wb_data;
    end
  end

  // Read port 1: zero in reset or for $0, bypass an in-flight commit, else storage
  always_comb begin
    readData1 = '0;
    if (reset) begin
      readData1 = '0;
    end else if (readReg1 == ZERO_IDX) begin
      readData1 = '0;
    end else if (w_commit && (writeReg == readReg1)) begin
      readData1 = w_wb_data;
    end else begin
      readData1 = r_regs[readReg1];
    end
  end

  // Read port 2: same rules as port 1, fully independent
  always_comb begin
    readData2 = '0;
    if (reset) begin
      readData2 = '0;
    end else if (readReg2 == ZERO_IDX) begin
      readData2 = '0;
    end else if (w_commit && (writeReg == readReg2)) begin
      readData2 = w_wb_data;
    end else begin
      readData2 = r_regs[readReg2];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic against an array-based reference model of the register file.
module tb_wb_regfile;

  logic        clock;
  logic        reset;
  logic        MemToReg;
  logic        RegWrite;
  logic [31:0] MemReadData;
  logic [31:0] address;
  logic [4:0]  writeReg;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] wbData;
  logic        wbValid;

  int vectors;
  int miscompares;

  // Reference architectural state
  logic [31:0] model [32];

  wb_regfile dut (
    .clock       (clock),
    .reset       (reset),
    .MemToReg    (MemToReg),
    .RegWrite    (RegWrite),
    .MemReadData (MemReadData),
    .address     (address),
    .writeReg    (writeReg),
    .readReg1    (readReg1),
    .readReg2    (readReg2),
    .readData1   (readData1),
    .readData2   (readData2),
    .wbData      (wbData),
    .wbValid     (wbValid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected write-back value from current inputs
  function automatic logic [31:0] exp_wb();
    return MemToReg ? MemReadData : address;
  endfunction

  // Expected commit flag from current inputs
  function automatic logic exp_valid();
    return (RegWrite === 1'b1) && (writeReg != 5'd0) && (reset === 1'b0);
  endfunction

  // Expected read value for a port index, from the architectural rules
  function automatic logic [31:0] exp_read(input logic [4:0] ra);
    if (reset) return 32'h0;
    if (ra == 5'd0) return 32'h0;
    if (exp_valid() && (writeReg == ra)) return exp_wb();
    return model[ra];
  endfunction

  // Drive a full input set after the falling edge, then let it settle
  task automatic apply(input logic rst, input logic rw, input logic mtr,
                       input logic [31:0] md, input logic [31:0] ad,
                       input logic [4:0] wr, input logic [4:0] r1,
                       input logic [4:0] r2);
    @(negedge clock);
    reset       = rst;
    RegWrite    = rw;
    MemToReg    = mtr;
    MemReadData = md;
    address     = ad;
    writeReg    = wr;
    readReg1    = r1;
    readReg2    = r2;
    #1;
  endtask

  // Advance through the rising edge and update the reference model
  task automatic clock_edge();
    logic        do_rst;
    logic        do_wr;
    logic [4:0]  wr;
    logic [31:0] val;
    do_rst = reset;
    do_wr  = exp_valid();
    wr     = writeReg;
    val    = exp_wb();
    @(posedge clock);
    if (do_rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (do_wr) begin
      model[wr] = val;
    end
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5);
    vectors++;
    if (wbValid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wbvalid: got %b expected 0", wbValid);
    end
    vectors++;
    if (readData1 !== 32'h0 || readData2 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_reads: got %h/%h expected 0", readData1, readData2);
    end
    vectors++;
    if (wbData !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL reset_wbdata: got %h expected deadbeef", wbData);
    end
    clock_edge();
    for (int i = 0; i < 32; i++) begin
      apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(31 - i));
      vectors++;
      if (readData1 !== 32'h0 || readData2 !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_clear r%0d: got %h/%h expected 0", i, readData1, readData2);
      end
    end
  endtask

  task automatic test_write_select();
    apply(1'b0, 1'b1, 1'b0, 32'h55555555, 32'h00000011, 5'd8, 5'd0, 5'd0);
    clock_edge();
    apply(1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 32'h0, 5'd9, 5'd8, 5'd0);
    vectors++;
    if (readData1 !== 32'h00000011) begin
      miscompares++;
      $display("FAIL alu_select: got %h expected 00000011", readData1);
    end
    vectors++;
    if (wbData !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL mem_select: got %h expected cafef00d", wbData);
    end
    clock_edge();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd9);
    vectors++;
    if (readData2 !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL mem_commit: got %h expected cafef00d", readData2);
    end
  endtask

  task automatic test_bypass();
    apply(1'b0, 1'b1, 1'b0, 32'h0, 32'h00000055, 5'd10, 5'd0, 5'd0);
    clock_edge();
    apply(1'b0, 1'b1, 1'b0, 32'h0, 32'h12345678, 5'd10, 5'd10, 5'd10);
    vectors++;
    if (readData1 !== 32'h12345678 || readData2 !== 32'h12345678) begin
      miscompares++;
      $display("FAIL bypass_same_cycle: got %h/%h expected 12345678", readData1, readData2);
    end
    clock_edge();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd10, 5'd10);
    vectors++;
    if (readData1 !== 32'h12345678 || readData2 !== 32'h12345678) begin
      miscompares++;
      $display("FAIL bypass_stored: got %h/%h expected 12345678", readData1, readData2);
    end
  endtask

  task automatic test_zero_reg();
    apply(1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    vectors++;
    if (wbValid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_wbvalid: got %b expected 0", wbValid);
    end
    vectors++;
    if (readData1 !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_same_cycle: got %h expected 0", readData1);
    end
    clock_edge();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    vectors++;
    if (readData1 !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_after: got %h expected 0", readData1);
    end
  endtask

  task automatic test_no_write();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 32'hAAAAAAAA, 5'd8, 5'd8, 5'd8);
    vectors++;
    if (readData1 !== 32'h00000011 || wbValid !== 1'b0) begin
      miscompares++;
      $display("FAIL nowrite_no_bypass: got %h v=%b expected 00000011 v=0", readData1, wbValid);
    end
    clock_edge();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 32'hAAAAAAAA, 5'bxxxxx, 5'd8, 5'd9);
    clock_edge();
    for (int i = 1; i < 32; i++) begin
      apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(i));
      vectors++;
      if (readData1 !== model[i]) begin
        miscompares++;
        $display("FAIL nowrite_keep r%0d: got %h expected %h", i, readData1, model[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0]  last_wr;
    logic [4:0]  wr;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ew;
    logic        ev;
    last_wr = 5'd1;
    for (int n = 0; n < 10000; n++) begin
      wr = ($urandom_range(0, 3) == 0) ? last_wr : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), $urandom, $urandom, wr, r1, r2);
      last_wr = wr;
      e1 = exp_read(r1);
      e2 = exp_read(r2);
      ew = exp_wb();
      ev = exp_valid();
      vectors++;
      if (readData1 !== e1) begin
        miscompares++;
        $display("FAIL rand_rd1 n=%0d: got %h expected %h", n, readData1, e1);
      end
      vectors++;
      if (readData2 !== e2) begin
        miscompares++;
        $display("FAIL rand_rd2 n=%0d: got %h expected %h", n, readData2, e2);
      end
      vectors++;
      if (wbData !== ew) begin
        miscompares++;
        $display("FAIL rand_wbdata n=%0d: got %h expected %h", n, wbData, ew);
      end
      vectors++;
      if (wbValid !== ev) begin
        miscompares++;
        $display("FAIL rand_wbvalid n=%0d: got %b expected %b", n, wbValid, ev);
      end
      clock_edge();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    RegWrite    = 1'b0;
    MemToReg    = 1'b0;
    MemReadData = 32'h0;
    address     = 32'h0;
    writeReg    = 5'd0;
    readReg1    = 5'd0;
    readReg2    = 5'd0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    test_reset();
    test_write_select();
    test_bypass();
    test_zero_reg();
    test_no_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage plus architectural register file for the 5-stage MIPS pipeline, sitting at the consuming end of the MEM/WB pipeline register. It picks write-back data (memory load data or ALU result) under MemToReg and commits it to a 32×32 register file on the clock edge when RegWrite is set. It serves the ID stage's two asynchronous read ports, with same-cycle write-through bypass so that ID never sees stale data for a register being written in WB. Register $0 is hardwired to zero.

## Interface
Parameters:
- DATA_W, 32, register and data width
- REG_ADDR_W, 5, register index width (32 registers)

Ports:
- clock  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  reset, synchronous and active-high; clears all registers
- MemToReg  input  1  from MEM/WB: 1 selects MemReadData, 0 selects address (ALU result)
- RegWrite  input  1  from MEM/WB: commit write-back this cycle
- MemReadData  input  DATA_W  from MEM/WB: load data
- address  input  DATA_W  from MEM/WB: ALU result
- writeReg  input  REG_ADDR_W  from MEM/WB: destination register index
- readReg1, readReg2  input  REG_ADDR_W  ID-stage source indices (rs, rt)
- readData1, readData2  output  DATA_W  ID-stage operand values
- wbData  output  DATA_W  selected write-back value, also routed to the EX forwarding mux
- wbValid  output  1  write-back commit this cycle: RegWrite && writeReg != 0 && !reset

## Operation
- wbData = MemToReg ? MemReadData : address. Purely combinational, independent of reset.
- Commit: on a rising edge with reset=0, RegWrite=1 and writeReg!=0, regs[writeReg] <= wbData. Writes to $0 are discarded.
- Reset: on a rising edge with reset=1, all 32 registers are set to 0. Reset takes priority over a simultaneous write, and that write is lost.
- Read port n (n=1,2):
  - if reset=1, readDataN = 0;
  - else if readRegN=0, readDataN = 0;
  - else if wbValid and writeReg==readRegN, readDataN = wbData (bypass);
  - else readDataN = regs[readRegN].
- Both ports are independent. They may address the same register, and both may bypass at once.
- There is no FSM. State is the register array only.

## Timing
- Write latency: the value is in storage after the edge on which it is presented. Through bypass, it is visible on the read ports in that same cycle, with zero latency.
- The read path is combinational from readRegN, the storage, and the WB inputs. There are no registered outputs.
- Output values at reset: readData1/2 = 0 and wbValid = 0 while reset is high. After the reset edge, every register reads 0.
- Reset deasserted mid-stream: the first commit can occur on the first edge with reset=0.
- Back-to-back writes to the same register: the last edge wins. A read in between returns the bypassed in-flight value.
- X on writeReg while RegWrite=0 must not alter storage.

## Structure
- Shared package mips_pkg holds:
  - REG_COUNT=32
  - ZERO_REG=5'd0
  - DATA_W/REG_ADDR_W defaults
- Sub-module wb_mux contains the 2:1 MemToReg select producing wbData. The register array and the bypass/read logic stay in wb_regfile.
- Expected size: about 120–180 lines.

## Test plan
- Reset: assert reset for 1 cycle with RegWrite=1, writeReg=5, address=0xDEADBEEF → after reset, readReg1=5 gives readData1=0, and wbValid was 0 during reset.
- Write/select:
  - MemToReg=0, address=0x00000011, writeReg=8, RegWrite=1 → next cycle readReg1=8 gives 0x00000011.
  - MemToReg=1, MemReadData=0xCAFEF00D to reg 9 → readReg2=9 gives 0xCAFEF00D.
- Bypass: same cycle as a commit of 0x12345678 to reg 10, readReg1=readReg2=10 → both read 0x12345678 before the edge; the old value is never visible.
- $0: RegWrite=1, writeReg=0, address=0xFFFFFFFF → wbValid=0, and readReg1=0 reads 0 in that cycle and after.
- RegWrite=0: present writeReg=8, address=0xAAAAAAAA → reg 8 keeps 0x00000011, with no bypass.
- Random: 10k cycles of random WB/read traffic against a reference model array, compared on every cycle, including same-index writes back-to-back and reset pulses mid-run.
